// File: rtl/qsfp_lane_mon.sv
// qsfp_lane_mon: per-lane lock debounce, lock timeout and RX reset pulse FSM
module qsfp_lane_mon #(
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT    = 1562500,
   parameter int RST_PULSE       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic lock,
   input  logic grant,
   output logic req,
   output logic rx_rst,
   output logic up,
   output logic down_evt
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
   localparam int PW = $clog2(RST_PULSE) + 1;
   typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_UP = 2'd1, ST_REQ = 2'd2, ST_RST = 2'd3} state_t;
   state_t state, state_nxt;
   logic [DW-1:0] deb, deb_nxt;
   logic [TW-1:0] tmo, tmo_nxt;
   logic [PW-1:0] pw, pw_nxt;
   // next state and counters; debounce wins over timeout in the same cycle
   always_comb begin
      state_nxt = state;
      deb_nxt = deb;
      tmo_nxt = tmo;
      pw_nxt = '0;
      case (state)
         ST_WAIT: begin
            deb_nxt = lock ? deb + DW'(deb != '1) : '0;
            tmo_nxt = tmo + TW'(tmo != '1);
            state_nxt = deb_nxt == DW'(DEBOUNCE_CYCLES) ? ST_UP :
                        tmo_nxt == TW'(LOCK_TIMEOUT) ? ST_REQ : ST_WAIT;
         end
         ST_UP: if (!lock) begin
            state_nxt = ST_WAIT;
            deb_nxt = '0;
            tmo_nxt = '0;
         end
         ST_REQ: if (grant) state_nxt = ST_RST;
         default: begin
            pw_nxt = pw + PW'(1);
            if (pw_nxt == PW'(RST_PULSE)) begin
               state_nxt = ST_WAIT;
               deb_nxt = '0;
               tmo_nxt = '0;
            end
         end
      endcase
   end
   // state, counters and registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_WAIT;
         deb <= '0;
         tmo <= '0;
         pw <= '0;
         req <= 1'b0;
         rx_rst <= 1'b0;
         up <= 1'b0;
         down_evt <= 1'b0;
      end else begin
         state <= state_nxt;
         deb <= deb_nxt;
         tmo <= tmo_nxt;
         pw <= pw_nxt;
         req <= state_nxt == ST_REQ;
         rx_rst <= state_nxt == ST_RST;
         up <= state_nxt == ST_UP;
         down_evt <= state == ST_UP && state_nxt == ST_WAIT;
      end
   end
endmodule

// File: rtl/qsfp_link_ctrl.sv
// qsfp_link_ctrl: QSFP28 lane supervisor with round-robin RX reset arbiter and status LEDs
module qsfp_link_ctrl #(
   parameter int LANES           = 4,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT    = 1562500,
   parameter int RST_PULSE       = 16,
   parameter int ACT_STRETCH     = 2500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] rx_block_lock,
   input  logic [LANES-1:0] rx_activity,
   output logic [LANES-1:0] lane_rx_rst,
   output logic [LANES-1:0] link_up,
   output logic [LANES-1:0] link_down_evt,
   output logic             led_act,
   output logic             led_stat_g,
   output logic             led_stat_y
);
   localparam int PTRW = LANES > 1 ? $clog2(LANES) : 1;
   localparam int AW = $clog2(ACT_STRETCH) + 1;
   logic [LANES-1:0] req, grant, grant_nxt;
   logic [PTRW-1:0] ptr, ptr_nxt, idx;
   logic [AW-1:0] act_cnt;
   logic found;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      qsfp_lane_mon #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LOCK_TIMEOUT(LOCK_TIMEOUT),
         .RST_PULSE(RST_PULSE)
      ) u_lane (
         .clk(clk),
         .rst(rst),
         .lock(rx_block_lock[i]),
         .grant(grant[i]),
         .req(req[i]),
         .rx_rst(lane_rx_rst[i]),
         .up(link_up[i]),
         .down_evt(link_down_evt[i])
      );
   end
   // grant the first requester at or after ptr, only while no pulse or grant is in flight
   always_comb begin
      grant_nxt = '0;
      ptr_nxt = ptr;
      found = 1'b0;
      idx = '0;
      for (int k = 0; k < LANES; k++) begin
         idx = PTRW'((int'(ptr) + k) % LANES);
         if (!found && !(|lane_rx_rst) && !(|grant) && req[idx]) begin
            found = 1'b1;
            grant_nxt[idx] = 1'b1;
            ptr_nxt = PTRW'((int'(idx) + 1) % LANES);
         end
      end
   end
   // arbiter state and activity stretcher
   always_ff @(posedge clk) begin
      if (rst) begin
         grant <= '0;
         ptr <= '0;
         act_cnt <= '0;
         led_act <= 1'b0;
      end else begin
         grant <= grant_nxt;
         ptr <= ptr_nxt;
         act_cnt <= |rx_activity ? AW'(ACT_STRETCH) : (act_cnt != '0) ? act_cnt - AW'(1) : act_cnt;
         led_act <= |rx_activity || act_cnt > AW'(1);
      end
   end
   assign led_stat_g = &link_up;
   assign led_stat_y = |link_up && !led_stat_g;
endmodule

// File: tb/tb_qsfp_link_ctrl.sv
// tb_qsfp_link_ctrl: table-driven and sequence checks for qsfp_link_ctrl
module tb_qsfp_link_ctrl;
   localparam int L = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [L-1:0] rx_block_lock = '0, rx_activity = '0;
   logic [L-1:0] lane_rx_rst, link_up, link_down_evt;
   logic led_act, led_stat_g, led_stat_y;
   int checks = 0, errors = 0, cyc = 0;
   typedef struct {int lane; int start; int width;} pulse_t;
   typedef struct {
      int n;
      logic [3:0] lock, act, up, dn, rr;
      logic g, y, la;
   } vec_t;
   pulse_t log_q[$];
   pulse_t exp_q[$];
   int start_c[L];
   logic [L-1:0] prev_rr = '0, rr_seen = '0;
   int last_fall = -1, overlap = 0, gap_err = 0;
   vec_t tv[13];

   always #5 clk = ~clk;

   qsfp_link_ctrl #(
      .LANES(L), .DEBOUNCE_CYCLES(8), .LOCK_TIMEOUT(64), .RST_PULSE(4), .ACT_STRETCH(16)
   ) dut (
      .clk(clk), .rst(rst), .rx_block_lock(rx_block_lock), .rx_activity(rx_activity),
      .lane_rx_rst(lane_rx_rst), .link_up(link_up), .link_down_evt(link_down_evt),
      .led_act(led_act), .led_stat_g(led_stat_g), .led_stat_y(led_stat_y)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         rr_seen |= lane_rx_rst;
         if ($countones(lane_rx_rst) > 1) overlap++;
         for (int l = 0; l < L; l++)
            if (!lane_rx_rst[l] && prev_rr[l]) begin
               log_q.push_back('{l, start_c[l], cyc - start_c[l]});
               last_fall = cyc;
            end
         for (int l = 0; l < L; l++)
            if (lane_rx_rst[l] && !prev_rr[l]) begin
               if (last_fall >= 0 && cyc <= last_fall) gap_err++;
               start_c[l] = cyc;
            end
         prev_rr = lane_rx_rst;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_block_lock = '0;
      rx_activity = '0;
      tick(2);
      rst = 1'b0;
      cyc = 0;
      log_q.delete();
      prev_rr = lane_rx_rst;
      rr_seen = '0;
      last_fall = -1;
      overlap = 0;
      gap_err = 0;
   endtask

   task automatic expect_pulse(input int l, input int s, input int w);
      exp_q.push_back('{l, s, w});
   endtask

   task automatic check_pulses(input string tag);
      pulse_t p;
      chk({tag, " pulse count"}, log_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < log_q.size()) p = log_q[i];
         else p = '{-1, -1, -1};
         chk($sformatf("%s pulse%0d lane", tag, i), p.lane, exp_q[i].lane);
         chk($sformatf("%s pulse%0d start", tag, i), p.start, exp_q[i].start);
         chk($sformatf("%s pulse%0d width", tag, i), p.width, exp_q[i].width);
      end
      exp_q.delete();
   endtask

   initial begin
      //        n   lock   act    up     dn     rr     g  y  la
      tv[0]  = '{0,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0};
      tv[1]  = '{10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0};
      tv[2]  = '{7,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0};
      tv[3]  = '{1,  4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0};
      tv[4]  = '{1,  4'hF, 4'h8, 4'hF, 4'h0, 4'h0, 1, 0, 1};
      tv[5]  = '{15, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 1};
      tv[6]  = '{1,  4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0};
      tv[7]  = '{1,  4'hD, 4'h0, 4'hD, 4'h2, 4'h0, 0, 1, 0};
      tv[8]  = '{1,  4'hD, 4'h0, 4'hD, 4'h0, 4'h0, 0, 1, 0};
      tv[9]  = '{8,  4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0};
      tv[10] = '{60, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0};
      tv[11] = '{1,  4'h6, 4'h0, 4'h6, 4'h9, 4'h0, 0, 1, 0};
      tv[12] = '{1,  4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 0, 0, 0};

      do_reset();
      foreach (tv[i]) begin
         rx_block_lock = tv[i].lock;
         rx_activity = tv[i].act;
         tick(tv[i].n);
         chk($sformatf("v%0d link_up", i), link_up, tv[i].up);
         chk($sformatf("v%0d link_down_evt", i), link_down_evt, tv[i].dn);
         chk($sformatf("v%0d lane_rx_rst", i), lane_rx_rst, tv[i].rr);
         chk($sformatf("v%0d led_stat_g", i), led_stat_g, tv[i].g);
         chk($sformatf("v%0d led_stat_y", i), led_stat_y, tv[i].y);
         chk($sformatf("v%0d led_act", i), led_act, tv[i].la);
      end
      chk("table no rx reset", rr_seen, 4'h0);

      do_reset();
      rx_block_lock = 4'hF;
      tick(5);
      rx_block_lock = 4'hE;
      tick(1);
      chk("restart cyc6 link_up", link_up, 4'h0);
      rx_block_lock = 4'hF;
      tick(7);
      chk("restart cyc13 link_up", link_up, 4'hE);
      tick(1);
      chk("restart cyc14 link_up", link_up, 4'hF);

      do_reset();
      rx_block_lock = 4'hB;
      tick(150);
      expect_pulse(2, 66, 4);
      expect_pulse(2, 136, 4);
      check_pulses("timeout");
      chk("timeout link_up", link_up, 4'hB);

      do_reset();
      tick(150);
      expect_pulse(0, 66, 4);
      expect_pulse(1, 72, 4);
      expect_pulse(2, 78, 4);
      expect_pulse(3, 84, 4);
      expect_pulse(0, 136, 4);
      expect_pulse(1, 142, 4);
      check_pulses("arb");
      chk("arb overlap", overlap, 0);
      chk("arb idle gap", gap_err, 0);

      do_reset();
      tick(60);
      rx_activity = 4'h8;
      tick(1);
      rx_activity = 4'h0;
      tick(6);
      chk("midrst pulse active", lane_rx_rst, 4'h1);
      chk("midrst led_act before", led_act, 1'b1);
      rst = 1'b1;
      tick(1);
      chk("midrst lane_rx_rst", lane_rx_rst, 4'h0);
      chk("midrst link_up", link_up, 4'h0);
      chk("midrst link_down_evt", link_down_evt, 4'h0);
      chk("midrst leds", {led_act, led_stat_g, led_stat_y}, 3'b000);
      rst = 1'b0;
      rr_seen = '0;
      tick(40);
      chk("midrst no resumed pulse", rr_seen, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
